// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, bus widths and the master state encoding.
// State codes follow a gray sequence along the normal transaction path.
package spi_pkg;

    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        START     = 3'b001,
        SHIFT_OUT = 3'b011,
        WAIT_RD   = 3'b010,
        SHIFT_IN  = 3'b110,
        GAP       = 3'b111
    } state_t;

    function automatic logic [1:0] cmd_op(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_W-1 -: 2];
    endfunction

endpackage

// File: rtl/spi_master.sv
// Single-clock SPI master: one 10-bit command per SS_n-low window, MSB first on MOSI;
// read-data commands capture 8 MISO bits RD_LAT cycles after the last command bit.
// Commands are accepted only in IDLE (cmd_ready); cmd_valid at any other time is dropped.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned RD_LAT   = 4,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 2);
    localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);
    localparam logic [3:0] OUT_LAST  = 4'(CMD_W - 1);
    localparam logic [3:0] IN_LAST   = 4'(DATA_W - 1);
    localparam bit         SKIP_WAIT = (RD_LAT == 1);

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [CMD_W-1:0]   sr, sr_nxt;
    logic [DATA_W-1:0]  rx, rx_nxt;
    logic [1:0]         op_q, op_nxt;
    logic [DATA_W-1:0]  rsp_data_nxt;
    logic               rsp_valid_nxt;
    logic               mosi_nxt;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sr_nxt        = sr;
        rx_nxt        = rx;
        op_nxt        = op_q;
        rsp_data_nxt  = rsp_data;
        rsp_valid_nxt = 1'b0;
        mosi_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    sr_nxt    = cmd_data;
                    op_nxt    = cmd_op(cmd_data);
                    cnt_nxt   = 4'd0;
                    mosi_nxt  = cmd_data[CMD_W-1];
                    state_nxt = START;
                end
            end
            START: begin
                // MOSI for the next cycle is taken before the shift, so C1 carries bit 9.
                mosi_nxt  = sr[CMD_W-1];
                sr_nxt    = {sr[CMD_W-2:0], 1'b0};
                cnt_nxt   = 4'd0;
                state_nxt = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                if (cnt == OUT_LAST) begin
                    cnt_nxt = 4'd0;
                    if (op_q == OP_RD_DATA) begin
                        state_nxt = SKIP_WAIT ? SHIFT_IN : WAIT_RD;
                    end else begin
                        state_nxt = GAP;
                    end
                end else begin
                    mosi_nxt = sr[CMD_W-1];
                    sr_nxt   = {sr[CMD_W-2:0], 1'b0};
                    cnt_nxt  = cnt + 4'd1;
                end
            end
            WAIT_RD: begin
                if (cnt == WAIT_LAST) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = SHIFT_IN;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            SHIFT_IN: begin
                rx_nxt = {rx[DATA_W-2:0], MISO};
                if (cnt == IN_LAST) begin
                    rsp_data_nxt  = {rx[DATA_W-2:0], MISO};
                    rsp_valid_nxt = 1'b1;
                    cnt_nxt       = 4'd0;
                    state_nxt     = GAP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                cnt_nxt   = 4'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            sr        <= '0;
            rx        <= '0;
            op_q      <= 2'b00;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sr        <= sr_nxt;
            rx        <= rx_nxt;
            op_q      <= op_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_valid <= rsp_valid_nxt;
            cmd_ready <= (state_nxt == IDLE);
            SS_n      <= (state_nxt == IDLE) || (state_nxt == GAP);
            MOSI      <= mosi_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + RAM and a read-byte scoreboard.
module tb_spi_master;
    import spi_pkg::*;

    localparam int RD_LAT   = 4;
    localparam int IDLE_GAP = 1;

    logic              CLK = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              SS_n;
    logic              MOSI;
    logic              MISO = 1'b0;

    spi_master #(.RD_LAT(RD_LAT), .IDLE_GAP(IDLE_GAP)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Slave + RAM model, evaluated mid-cycle. lc is the index of the current SS_n-low cycle.
    int         lc = -1;
    int         tc = 0;
    logic       prev_ss = 1'b1;
    logic [9:0] srx = '0;
    logic [7:0] mem [256];
    logic [7:0] s_addr = '0;
    logic [7:0] txb = '0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always @(negedge CLK) begin
        if (!SS_n) lc = lc + 1;
        else       lc = -1;
        if (lc >= 1 && lc <= 10) srx = {srx[8:0], MOSI};
        if (lc == 10) begin
            case (srx[9:8])
                OP_WR_ADDR, OP_RD_ADDR: s_addr = srx[7:0];
                OP_WR_DATA:             mem[s_addr] = srx[7:0];
                default:                txb = mem[s_addr];
            endcase
        end
        if (lc >= 14 && lc <= 21) MISO = txb[21 - lc];
        else                      MISO = 1'b0;

        if (!SS_n && prev_ss) tc = 0;
        else                  tc = tc + 1;
        prev_ss = SS_n;

        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", rsp_valid, 1'b0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e);
                chk("rsp_cycle", tc, 18 + RD_LAT);
            end
        end
    end

    // Returns at the mid-point of C0 of the accepted transaction.
    task automatic send(input logic [9:0] c);
        int k;
        k = 0;
        while (!cmd_ready && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk("scoreboard_drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ss_v;
        logic [9:0]  mo_v;
        logic        busy_rdy;
        int          f0, f1, falls;
        logic        prv;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ss_n", SS_n, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        rst = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", cmd_ready, 1'b1);

        // Write address 0x14: frame shape and bit order.
        send(10'b00_0001_0100);
        ss_v = '0; mo_v = '0; busy_rdy = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ss_v[k] = SS_n;
            if (k >= 1 && k <= 10) mo_v = {mo_v[8:0], MOSI};
            if (k <= 10) busy_rdy = busy_rdy | cmd_ready;
            @(negedge CLK);
        end
        chk("wr_addr_ss_n", ss_v, 12'h800);
        chk("wr_addr_mosi", mo_v, 10'h014);
        chk("wr_addr_ready_low", busy_rdy, 1'b0);

        // Write 0xA5, read address 0x14, read data.
        send(10'h1A5);
        send(10'h214);
        exp_q.push_back(8'hA5);
        send(10'h300);
        drain();
        @(negedge CLK);
        chk("rsp_valid_pulse", rsp_valid, 1'b0);
        chk("rsp_data_held_a5", rsp_data, 8'hA5);

        // Back-to-back writes with cmd_valid held high.
        while (!cmd_ready) @(negedge CLK);
        cmd_data  = 10'h022;
        cmd_valid = 1'b1;
        f0 = -1; f1 = -1; busy_rdy = 1'b0; prv = SS_n;
        for (int t = 0; t < 60; t++) begin
            @(negedge CLK);
            if (!SS_n && prv) begin
                if (f0 < 0) f0 = t;
                else if (f1 < 0) begin
                    f1 = t;
                    cmd_valid = 1'b0;
                end
            end
            if (!SS_n && cmd_ready) busy_rdy = 1'b1;
            prv = SS_n;
        end
        cmd_valid = 1'b0;
        chk("b2b_spacing", f1 - f0, 12 + IDLE_GAP);
        chk("b2b_ready_low", busy_rdy, 1'b0);

        // Slave returns 0x3C.
        send(10'h030);
        send(10'h13C);
        send(10'h230);
        exp_q.push_back(8'h3C);
        send(10'h300);
        drain();
        @(negedge CLK);
        chk("rsp_valid_single", rsp_valid, 1'b0);
        repeat (5) @(negedge CLK);
        chk("rsp_data_held_3c", rsp_data, 8'h3C);

        // Reset in C5 of a read-data transaction (MOSI is 1 in C5 here).
        send(10'h3FF);
        repeat (5) @(negedge CLK);
        chk("pre_rst_mosi_c5", MOSI, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_ss_n", SS_n, 1'b1);
        chk("midrst_mosi", MOSI, 1'b0);
        chk("midrst_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        chk("ready_after_midrst", cmd_ready, 1'b1);
        send(10'h214);
        exp_q.push_back(8'hA5);
        send(10'h300);
        drain();

        // cmd_valid pulsed during SHIFT_OUT is dropped.
        send(10'h040);
        repeat (4) @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_data  = 10'h055;
        chk("shift_out_ready_low", cmd_ready, 1'b0);
        @(negedge CLK);
        cmd_valid = 1'b0;
        falls = 0; prv = SS_n;
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            if (!SS_n && prv) falls++;
            prv = SS_n;
        end
        chk("ignored_cmd_no_start", falls, 0);
        chk("idle_ss_n", SS_n, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
